ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, RAM byte-address width forwarded to the RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed at 32. Any other value is a configuration error caught at elaboration.
REQ-003 SHALL have one clock and an asynchronous active-high reset: clk (rising edge), rst.
REQ-004 clk  in  1  clock
REQ-005 rst  in  1  async reset, active high
REQ-006 instr_req_i  in  1  fetch request
REQ-007 instr_addr_i  in  32  fetch byte address
REQ-008 instr_gnt_o  out  1  fetch accepted this cycle
REQ-009 instr_rvalid_o  out  1  fetch data valid on rdata_o
REQ-010 data_req_i  in  1  load/store request
REQ-011 data_we_i  in  1  1 = store
REQ-012 data_be_i  in  4  byte enables
REQ-013 data_addr_i  in  32  load/store byte address
REQ-014 data_wdata_i  in  32  store data
REQ-015 data_gnt_o  out  1  load/store accepted this cycle
REQ-016 data_rvalid_o  out  1  load data valid / store complete
REQ-017 rdata_o  out  32  read data, shared by both ports
REQ-018 ram_en_o / ram_we_o  out  1 / 1  RAM enable / write enable
REQ-019 ram_addr_o  out  ADDR_WIDTH  RAM byte address
REQ-020 ram_be_o / ram_wdata_o  out  4 / 32  RAM byte enables / write data
REQ-021 ram_rdata_i  in  32  RAM read data, registered by the RAM, valid 1 cycle after ram_en_o

Function
REQ-022 SHALL grant at most one requester per cycle; gnt is combinational from req and arbitration state. No request is refused when it is the only one pending.
REQ-023 On a grant, SHALL drive ram_en_o=1 with ram_addr_o = winner addr[ADDR_WIDTH-1:0] in the same cycle. Upper address bits are ignored and wrap.
REQ-024 Instr grant SHALL drive ram_we_o=0 and ram_be_o=4'hF. Data grant SHALL pass through we, be and wdata unchanged.
REQ-025 No grant SHALL drive ram_en_o=0 and ram_we_o=0. ram_addr_o, ram_be_o and ram_wdata_o are don't-care in that case.
REQ-026 A registered owner flag (instr/data/none) SHALL record each grant. In the next cycle exactly the matching rvalid pulses for 1 cycle.
REQ-027 rvalid SHALL also pulse for stores.
REQ-028 rdata_o SHALL equal ram_rdata_i combinationally. It is meaningful only while an rvalid is high.
REQ-029 Back-to-back grants SHALL be supported at full throughput, one transaction per cycle, with no bubble.
REQ-030 Requesters keep req/addr stable until gnt; the arbiter holds no request state.
REQ-031 Contention policy with the macro undefined: data always wins over instr.

Reset
REQ-032 While rst=1: instr_rvalid_o=0, data_rvalid_o=0, owner=none, gnt outputs=0, ram_en_o=0, ram_we_o=0. The round-robin last-winner flag resets to "instr".
REQ-033 Assertion of rst mid-transaction SHALL drop a pending rvalid; no rvalid is issued after rst deasserts for a pre-reset grant.

Configuration
REQ-034 Macro RAM_ARB_ROUND_ROBIN_EN defined: under contention the port not granted last wins. The last-winner flag updates only on a grant, so the first contention after reset goes to data.
REQ-035 Macro RAM_ARB_ROUND_ROBIN_EN undefined: fixed data-over-instr priority per REQ-031. The last-winner flag is not implemented.

Verification
REQ-036 Instr only: addr 0x0000_0010, RAM word 0x0000_0010 = 0xDEADBEEF -> instr_gnt_o=1, ram_en_o=1, ram_addr_o=0x0010, ram_we_o=0; next cycle instr_rvalid_o=1, rdata_o=0xDEADBEEF, data_rvalid_o=0.
REQ-037 Data store at 0x0000_0020, be=4'b0011, wdata=0x12345678, then load 0x20 (RAM previously 0xFFFFFFFF) -> store rvalid pulses; load returns 0xFFFF5678.
REQ-038 Both request every cycle for 4 cycles, macro undefined -> data granted 4/4, instr 0, instr_gnt_o=0 throughout.
REQ-039 Same stimulus with RAM_ARB_ROUND_ROBIN_EN -> grant order data, instr, data, instr; rvalids follow one cycle later in that order.
REQ-040 Wrap and reset: instr_addr_i=0x0001_0004 -> ram_addr_o=0x0004. Assert rst the cycle after a data grant -> data_rvalid_o stays 0 and no rvalid appears after release.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port (instruction fetch / load-store) arbiter in front of a
// single-ported synchronous RAM with one-cycle registered read data.
// Optional feature: define RAM_ARB_ROUND_ROBIN_EN to make contention alternate
// between the ports; otherwise the data port always wins over the instr port.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   // instruction fetch port
   input  logic                  instr_req_i,
   input  logic [31:0]           instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   // load/store port
   input  logic                  data_req_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   // shared read data
   output logic [DATA_WIDTH-1:0] rdata_o,
   // RAM side
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [3:0]            ram_be_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

   // The byte-enable and port widths assume 32-bit words; refuse anything else.
   generate
      if (DATA_WIDTH != 32) begin : g_bad_width
         $error("ram_arbiter: DATA_WIDTH must be 32");
      end
   endgenerate

   // Upper address bits beyond the RAM size are dropped so accesses wrap.
   generate
      if (ADDR_WIDTH < 32) begin : g_addr_unused
         logic unused_addr_hi;
         assign unused_addr_hi = ^{instr_addr_i[31:ADDR_WIDTH], data_addr_i[31:ADDR_WIDTH]};
      end
   endgenerate

   // Who owns the read data returning next cycle.
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   owner_e owner_q, owner_d;
   logic   data_wins;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   // 1 = data port won the most recent grant; reset value means "instr".
   logic last_data_q;

   // Under contention the port that did not win last time goes first.
   always_comb begin
      data_wins = data_req_i && (!instr_req_i || !last_data_q);
   end

   // Remember the last winner; only a real grant moves it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_data_q <= 1'b0;
      else if (owner_d == OWN_DATA)
         last_data_q <= 1'b1;
      else if (owner_d == OWN_INSTR)
         last_data_q <= 1'b0;
   end
`else
   // Fixed priority: a load/store request always beats a fetch.
   always_comb begin
      data_wins = data_req_i;
   end
`endif

   // Grant selection and RAM request mux; no grant at all while in reset.
   always_comb begin
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = instr_addr_i[ADDR_WIDTH-1:0];
      ram_be_o    = 4'hF;
      ram_wdata_o = data_wdata_i;
      owner_d     = OWN_NONE;
      if (!rst) begin
         if (data_wins) begin
            data_gnt_o = 1'b1;
            ram_en_o   = 1'b1;
            ram_we_o   = data_we_i;
            ram_addr_o = data_addr_i[ADDR_WIDTH-1:0];
            ram_be_o   = data_be_i;
            owner_d    = OWN_DATA;
         end else if (instr_req_i) begin
            instr_gnt_o = 1'b1;
            ram_en_o    = 1'b1;
            ram_addr_o  = instr_addr_i[ADDR_WIDTH-1:0];
            owner_d     = OWN_INSTR;
         end
      end
   end

   // Owner flag: async reset discards any response still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         owner_q <= OWN_NONE;
      else
         owner_q <= owner_d;
   end

   // Response side: one rvalid pulse per grant, data straight from the RAM.
   always_comb begin
      instr_rvalid_o = (owner_q == OWN_INSTR);
      data_rvalid_o  = (owner_q == OWN_DATA);
      rdata_o        = ram_rdata_i;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small byte-enabled synchronous RAM model.
module tb_ram_arbiter;

   localparam int AW = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_req_i = 1'b0;
   logic [31:0] instr_addr_i = '0;
   logic        instr_gnt_o, instr_rvalid_o;
   logic        data_req_i = 1'b0;
   logic        data_we_i = 1'b0;
   logic [3:0]  data_be_i = 4'h0;
   logic [31:0] data_addr_i = '0;
   logic [31:0] data_wdata_i = '0;
   logic        data_gnt_o, data_rvalid_o;
   logic [31:0] rdata_o;
   logic        ram_en_o, ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [3:0]  ram_be_o;
   logic [31:0] ram_wdata_o;
   logic [31:0] ram_rdata_i = '0;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:(1<<(AW-2))-1];

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .rdata_o(rdata_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   // RAM model: read-before-write, registered read data, byte-enabled writes.
   always @(posedge clk) begin
      if (ram_en_o) begin
         ram_rdata_i <= mem[ram_addr_o[AW-1:2]];
         if (ram_we_o)
            for (int b = 0; b < 4; b++)
               if (ram_be_o[b]) mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, then settle before checking.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < (1<<(AW-2)); i++) mem[i] = 32'h0;
      mem[4] = 32'hDEADBEEF;   // byte 0x10
      mem[8] = 32'hFFFFFFFF;   // byte 0x20
      mem[1] = 32'hA5A50001;   // byte 0x04

      // Reset held with both ports requesting: nothing may be granted.
      instr_req_i = 1'b1; instr_addr_i = 32'h10;
      data_req_i  = 1'b1; data_addr_i  = 32'h20; data_we_i = 1'b1; data_be_i = 4'hF;
      step(); step();
      #3;
      chk("rst_instr_gnt", {31'b0, instr_gnt_o}, 0);
      chk("rst_data_gnt", {31'b0, data_gnt_o}, 0);
      chk("rst_ram_en", {31'b0, ram_en_o}, 0);
      chk("rst_ram_we", {31'b0, ram_we_o}, 0);
      chk("rst_rvalids", {30'b0, instr_rvalid_o, data_rvalid_o}, 0);
      instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
      step();
      rst = 1'b0;

      // Instruction fetch only.
      step();
      instr_req_i = 1'b1; instr_addr_i = 32'h0000_0010;
      #3;
      chk("if_gnt", {31'b0, instr_gnt_o}, 1);
      chk("if_dgnt", {31'b0, data_gnt_o}, 0);
      chk("if_en", {31'b0, ram_en_o}, 1);
      chk("if_addr", {16'b0, ram_addr_o}, 32'h0010);
      chk("if_we", {31'b0, ram_we_o}, 0);
      chk("if_be", {28'b0, ram_be_o}, 32'hF);
      step();
      instr_req_i = 1'b0;
      #3;
      chk("if_rvalid", {31'b0, instr_rvalid_o}, 1);
      chk("if_rdata", rdata_o, 32'hDEADBEEF);
      chk("if_drvalid", {31'b0, data_rvalid_o}, 0);
      chk("idle_en", {31'b0, ram_en_o}, 0);

      // Partial store then back-to-back load of the same word.
      step();
      chk("idle_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 0);
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
      data_addr_i = 32'h20; data_wdata_i = 32'h12345678;
      #3;
      chk("st_gnt", {31'b0, data_gnt_o}, 1);
      chk("st_we", {31'b0, ram_we_o}, 1);
      chk("st_be", {28'b0, ram_be_o}, 32'h3);
      chk("st_wdata", ram_wdata_o, 32'h12345678);
      chk("st_addr", {16'b0, ram_addr_o}, 32'h0020);
      step();
      data_we_i = 1'b0; data_be_i = 4'hF;
      #3;
      chk("st_rvalid", {31'b0, data_rvalid_o}, 1);
      chk("ld_gnt", {31'b0, data_gnt_o}, 1);
      chk("ld_we", {31'b0, ram_we_o}, 0);
      step();
      data_req_i = 1'b0;
      #3;
      chk("ld_rvalid", {31'b0, data_rvalid_o}, 1);
      chk("ld_rdata", rdata_o, 32'hFFFF5678);
      chk("ld_irvalid", {31'b0, instr_rvalid_o}, 0);

      // Fetch with address above the RAM size wraps.
      step();
      instr_req_i = 1'b1; instr_addr_i = 32'h0001_0004;
      #3;
      chk("wrap_gnt", {31'b0, instr_gnt_o}, 1);
      chk("wrap_addr", {16'b0, ram_addr_o}, 32'h0004);
      step();
      instr_req_i = 1'b0;
      #3;
      chk("wrap_rvalid", {31'b0, instr_rvalid_o}, 1);
      chk("wrap_rdata", rdata_o, 32'hA5A50001);

      // Contention for four cycles, last winner was instr.
      step();
      instr_req_i = 1'b1; instr_addr_i = 32'h10;
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h20;
      #3;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      chk("c0_gnt", {30'b0, data_gnt_o, instr_gnt_o}, 32'b10);
      step(); #3;
      chk("c1_gnt", {30'b0, data_gnt_o, instr_gnt_o}, 32'b01);
      chk("c1_rv", {30'b0, data_rvalid_o, instr_rvalid_o}, 32'b10);
      step(); #3;
      chk("c2_gnt", {30'b0, data_gnt_o, instr_gnt_o}, 32'b10);
      chk("c2_rv", {30'b0, data_rvalid_o, instr_rvalid_o}, 32'b01);
      chk("c2_rdata", rdata_o, 32'hDEADBEEF);
      step(); #3;
      chk("c3_gnt", {30'b0, data_gnt_o, instr_gnt_o}, 32'b01);
      chk("c3_rv", {30'b0, data_rvalid_o, instr_rvalid_o}, 32'b10);
      step();
      instr_req_i = 1'b0; data_req_i = 1'b0;
      #3;
      chk("c4_rv", {30'b0, data_rvalid_o, instr_rvalid_o}, 32'b01);
`else
      chk("c0_gnt", {30'b0, data_gnt_o, instr_gnt_o}, 32'b10);
      step(); #3;
      chk("c1_gnt", {30'b0, data_gnt_o, instr_gnt_o}, 32'b10);
      chk("c1_rv", {30'b0, data_rvalid_o, instr_rvalid_o}, 32'b10);
      step(); #3;
      chk("c2_gnt", {30'b0, data_gnt_o, instr_gnt_o}, 32'b10);
      chk("c2_rv", {30'b0, data_rvalid_o, instr_rvalid_o}, 32'b10);
      chk("c2_rdata", rdata_o, 32'hFFFF5678);
      step(); #3;
      chk("c3_gnt", {30'b0, data_gnt_o, instr_gnt_o}, 32'b10);
      chk("c3_rv", {30'b0, data_rvalid_o, instr_rvalid_o}, 32'b10);
      step();
      instr_req_i = 1'b0; data_req_i = 1'b0;
      #3;
      chk("c4_rv", {30'b0, data_rvalid_o, instr_rvalid_o}, 32'b10);
`endif

      // Reset lands the cycle after a data grant: the response is dropped.
      step();
      data_req_i = 1'b1; data_addr_i = 32'h20;
      #3;
      chk("pr_gnt", {31'b0, data_gnt_o}, 1);
      step();
      rst = 1'b1;
      #3;
      chk("pr_rvalid_drop", {31'b0, data_rvalid_o}, 0);
      chk("pr_gnt_rst", {31'b0, data_gnt_o}, 0);
      chk("pr_en_rst", {31'b0, ram_en_o}, 0);
      step();
      data_req_i = 1'b0;
      step();
      rst = 1'b0;
      #3;
      chk("post_rv0", {30'b0, data_rvalid_o, instr_rvalid_o}, 0);
      step(); #3;
      chk("post_rv1", {30'b0, data_rvalid_o, instr_rvalid_o}, 0);

      // First contention after reset goes to data in either build.
      instr_req_i = 1'b1; data_req_i = 1'b1;
      #1;
      chk("post_cont", {30'b0, data_gnt_o, instr_gnt_o}, 32'b10);
      step();
      instr_req_i = 1'b0; data_req_i = 1'b0;
      #3;
      chk("post_cont_rv", {30'b0, data_rvalid_o, instr_rvalid_o}, 32'b10);

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
